// File: rtl/writeback_unit_pkg.sv
// Shared types for the register-file writeback path: widths, the write
// request struct and a helper that turns a destination into a pending mask.
package writeback_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // x0 is never a real destination, so it never contributes to the mask
    function automatic logic [NUM_REGS-1:0] rd_mask(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Core-facing bundle of the writeback unit: ALU and load result inputs,
// read-port forwarding, pending mask and the register-file write port.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic                  alu_valid_i;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [XLEN-1:0]       alu_data_i;
    logic                  alu_stall_o;

    logic                  mem_valid_i;
    logic [REG_ADDR_W-1:0] mem_rd_i;
    logic [XLEN-1:0]       mem_data_i;
    logic                  mem_ready_o;

    logic [REG_ADDR_W-1:0] rs1_addr_i;
    logic [REG_ADDR_W-1:0] rs2_addr_i;
    logic                  rs1_fwd_valid_o;
    logic                  rs2_fwd_valid_o;
    logic [XLEN-1:0]       rs1_fwd_data_o;
    logic [XLEN-1:0]       rs2_fwd_data_o;

    logic [NUM_REGS-1:0]   pending_o;

    logic                  wr_en_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [XLEN-1:0]       data_o;

    modport master (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  mem_valid_i, mem_rd_i, mem_data_i,
        input  rs1_addr_i, rs2_addr_i,
        output alu_stall_o, mem_ready_o,
        output rs1_fwd_valid_o, rs2_fwd_valid_o, rs1_fwd_data_o, rs2_fwd_data_o,
        output pending_o, wr_en_o, rd_addr_o, data_o
    );

    modport slave (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output mem_valid_i, mem_rd_i, mem_data_i,
        output rs1_addr_i, rs2_addr_i,
        input  alu_stall_o, mem_ready_o,
        input  rs1_fwd_valid_o, rs2_fwd_valid_o, rs1_fwd_data_o, rs2_fwd_data_o,
        input  pending_o, wr_en_o, rd_addr_o, data_o
    );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Synchronous FIFO of write requests; exposes a per-entry valid/rd view so
// the parent can build a pending-destination mask without extra state.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wb_req_t                          push_req,
    input  logic                             pop,
    output wb_req_t                          head,
    output logic [CNT_W-1:0]                 count,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0]                 ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);

    wb_req_t           mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_req;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // An entry is live when its distance from the read pointer is below count
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] off;
        assign off        = PTR_W'(i) - rptr;
        assign ent_vld[i] = ({1'b0, off} < count);
        assign ent_rd[i]  = mem[i].rd;
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write initiator: ALU results win by default, load results
// queue behind them, and a starvation counter forces the queue out periodically.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    writeback_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    wb_req_t                                   fifo_head;
    logic [CNT_W-1:0]                          fifo_count;
    logic                                      fifo_full;
    logic                                      fifo_empty;
    logic [FIFO_DEPTH-1:0]                     ent_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd;

    logic [SC_W-1:0] starve_cnt;
    logic            stall;
    logic            mem_ready;
    logic            mem_acc;
    logic            alu_win;
    logic            fifo_win;
    logic            direct_win;
    logic            push;
    logic            win_vld;
    wb_req_t         win_req;
    wb_req_t         mem_req;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       data;
    logic [NUM_REGS-1:0]   pending;

    assign mem_req = '{rd: bus.mem_rd_i, data: bus.mem_data_i};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (mem_req),
        .pop      (fifo_win),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ent_vld  (ent_vld),
        .ent_rd   (ent_rd)
    );

    assign stall = (starve_cnt == SC_W'(STARVE_LIMIT));

    // Priority: ALU, then queued loads, then a load arriving at an empty queue
    always_comb begin
        mem_ready  = !rst && !fifo_full;
        mem_acc    = bus.mem_valid_i && mem_ready;
        alu_win    = bus.alu_valid_i && !stall;
        fifo_win   = !alu_win && !fifo_empty;
        direct_win = !alu_win && fifo_empty && mem_acc;
        push       = mem_acc && !direct_win;
        win_vld    = alu_win || fifo_win || direct_win;
        win_req    = mem_req;
        if (alu_win)
            win_req = '{rd: bus.alu_rd_i, data: bus.alu_data_i};
        else if (fifo_win)
            win_req = fifo_head;
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (alu_win && !fifo_empty)
            starve_cnt <= starve_cnt + 1'b1;
        else
            starve_cnt <= '0;
    end

    // x0 winners still take the slot but never reach the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            rd_addr <= '0;
            data    <= '0;
        end else if (win_vld) begin
            wr_en   <= (win_req.rd != '0);
            rd_addr <= win_req.rd;
            data    <= win_req.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_vld[i])
                pending = pending | rd_mask(ent_rd[i]);
    end

    assign bus.alu_stall_o     = stall;
    assign bus.mem_ready_o     = mem_ready;
    assign bus.pending_o       = pending;
    assign bus.wr_en_o         = wr_en;
    assign bus.rd_addr_o       = rd_addr;
    assign bus.data_o          = data;

    assign bus.rs1_fwd_valid_o = wr_en && (rd_addr == bus.rs1_addr_i) && (bus.rs1_addr_i != '0);
    assign bus.rs2_fwd_valid_o = wr_en && (rd_addr == bus.rs2_addr_i) && (bus.rs2_addr_i != '0);
    assign bus.rs1_fwd_data_o  = bus.rs1_fwd_valid_o ? data : '0;
    assign bus.rs2_fwd_data_o  = bus.rs2_fwd_valid_o ? data : '0;

endmodule

// File: tb/tb_writeback_unit.sv
// Scenario bench for writeback_unit: expected writes are queued as stimulus
// is driven and a negedge monitor checks every register-file write in order.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if bus ();

    writeback_unit #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    wb_req_t exp_q[$];
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (bus.wr_en_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got rd=%0d data=%h, required no write", bus.rd_addr_o, bus.data_o);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (bus.rd_addr_o !== e.rd || bus.data_o !== e.data) begin
                    bad++;
                    $display("FAIL write_order got rd=%0d data=%h, required rd=%0d data=%h",
                             bus.rd_addr_o, bus.data_o, e.rd, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid_i = 1'b0;
        bus.alu_rd_i    = '0;
        bus.alu_data_i  = '0;
        bus.mem_valid_i = 1'b0;
        bus.mem_rd_i    = '0;
        bus.mem_data_i  = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = rd;
        bus.alu_data_i  = d;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [31:0] d);
        bus.mem_valid_i = 1'b1;
        bus.mem_rd_i    = rd;
        bus.mem_data_i  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.rs1_addr_i = '0;
        bus.rs2_addr_i = '0;
        tick();
        total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b required 0", bus.wr_en_o); end
        total++; if (bus.rd_addr_o !== 5'd0) begin bad++; $display("FAIL reset_rd_addr got %0d required 0", bus.rd_addr_o); end
        total++; if (bus.data_o !== 32'd0) begin bad++; $display("FAIL reset_data got %h required 0", bus.data_o); end
        total++; if (bus.alu_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got %b required 0", bus.alu_stall_o); end
        total++; if (bus.pending_o !== 32'd0) begin bad++; $display("FAIL reset_pending got %h required 0", bus.pending_o); end
        total++; if (bus.mem_ready_o !== 1'b0) begin bad++; $display("FAIL reset_mem_ready got %b required 0", bus.mem_ready_o); end
        rst = 1'b0;
        #1;
        total++; if (bus.mem_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_mem_ready got %b required 1", bus.mem_ready_o); end
        tick();
    endtask

    task automatic test_alu_only();
        drive_alu(5'd5, 32'hDEADBEEF);
        exp_q.push_back(wb_req_t'{rd: 5'd5, data: 32'hDEADBEEF});
        tick();
        idle();
        bus.rs1_addr_i = 5'd5;
        bus.rs2_addr_i = 5'd6;
        #1;
        total++; if (bus.wr_en_o !== 1'b1) begin bad++; $display("FAIL alu_wr_en got %b required 1", bus.wr_en_o); end
        total++; if (bus.rs1_fwd_valid_o !== 1'b1) begin bad++; $display("FAIL alu_fwd1_valid got %b required 1", bus.rs1_fwd_valid_o); end
        total++; if (bus.rs1_fwd_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_fwd1_data got %h required deadbeef", bus.rs1_fwd_data_o); end
        total++; if (bus.rs2_fwd_valid_o !== 1'b0) begin bad++; $display("FAIL alu_fwd2_valid got %b required 0", bus.rs2_fwd_valid_o); end
        total++; if (bus.rs2_fwd_data_o !== 32'd0) begin bad++; $display("FAIL alu_fwd2_data got %h required 0", bus.rs2_fwd_data_o); end
        tick();
        bus.rs1_addr_i = '0;
        bus.rs2_addr_i = '0;
    endtask

    task automatic test_collision();
        drive_alu(5'd3, 32'h11);
        drive_mem(5'd7, 32'h22);
        exp_q.push_back(wb_req_t'{rd: 5'd3, data: 32'h11});
        exp_q.push_back(wb_req_t'{rd: 5'd7, data: 32'h22});
        #1;
        total++; if (bus.mem_ready_o !== 1'b1) begin bad++; $display("FAIL coll_mem_ready got %b required 1", bus.mem_ready_o); end
        tick();
        idle();
        #1;
        total++; if (bus.pending_o !== 32'h0000_0080) begin bad++; $display("FAIL coll_pending got %h required 00000080", bus.pending_o); end
        tick();
        #1;
        total++; if (bus.pending_o !== 32'd0) begin bad++; $display("FAIL coll_pending_clr got %h required 0", bus.pending_o); end
        total++; if (bus.rd_addr_o !== 5'd7) begin bad++; $display("FAIL coll_load_rd got %0d required 7", bus.rd_addr_o); end
        tick();
    endtask

    task automatic test_backpressure();
        bit rdy_exp   [7] = '{1, 1, 0, 0, 0, 0, 1};
        bit stall_exp [7] = '{0, 0, 0, 0, 0, 1, 0};
        int ai = 0;
        int li = 0;
        for (int k = 0; k < 5; k++)
            exp_q.push_back(wb_req_t'{rd: 5'(10 + k), data: 32'hA000_0000 + 32'(k)});
        exp_q.push_back(wb_req_t'{rd: 5'd20, data: 32'hB000_0000});
        exp_q.push_back(wb_req_t'{rd: 5'd15, data: 32'hA000_0005});
        exp_q.push_back(wb_req_t'{rd: 5'd21, data: 32'hB000_0001});
        exp_q.push_back(wb_req_t'{rd: 5'd22, data: 32'hB000_0002});
        for (int c = 0; c < 7; c++) begin
            drive_alu(5'(10 + ai), 32'hA000_0000 + 32'(ai));
            if (li < 3) drive_mem(5'(20 + li), 32'hB000_0000 + 32'(li));
            else        bus.mem_valid_i = 1'b0;
            #1;
            total++;
            if (bus.mem_ready_o !== rdy_exp[c]) begin
                bad++; $display("FAIL bp_mem_ready cycle %0d got %b required %b", c, bus.mem_ready_o, rdy_exp[c]);
            end
            total++;
            if (bus.alu_stall_o !== stall_exp[c]) begin
                bad++; $display("FAIL bp_stall cycle %0d got %b required %b", c, bus.alu_stall_o, stall_exp[c]);
            end
            if (c == 2) begin
                total++;
                if (bus.pending_o !== 32'h0030_0000) begin
                    bad++; $display("FAIL bp_pending got %h required 00300000", bus.pending_o);
                end
            end
            if (!stall_exp[c]) ai++;
            if (li < 3 && rdy_exp[c]) li++;
            tick();
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_x0();
        drive_alu(5'd0, 32'hFFFFFFFF);
        bus.rs1_addr_i = 5'd0;
        tick();
        idle();
        #1;
        total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL x0_alu_wr_en got %b required 0", bus.wr_en_o); end
        total++; if (bus.rs1_fwd_valid_o !== 1'b0) begin bad++; $display("FAIL x0_fwd_valid got %b required 0", bus.rs1_fwd_valid_o); end
        tick();
        drive_alu(5'd9, 32'h99);
        drive_mem(5'd0, 32'h1234);
        exp_q.push_back(wb_req_t'{rd: 5'd9, data: 32'h99});
        tick();
        idle();
        #1;
        total++; if (bus.pending_o !== 32'd0) begin bad++; $display("FAIL x0_pending got %h required 0", bus.pending_o); end
        tick();
        #1;
        total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL x0_load_wr_en got %b required 0", bus.wr_en_o); end
        tick();
    endtask

    task automatic test_full_pushpop();
        exp_q.push_back(wb_req_t'{rd: 5'd1,  data: 32'hC1});
        exp_q.push_back(wb_req_t'{rd: 5'd2,  data: 32'hC2});
        exp_q.push_back(wb_req_t'{rd: 5'd24, data: 32'hD0});
        exp_q.push_back(wb_req_t'{rd: 5'd25, data: 32'hD1});
        exp_q.push_back(wb_req_t'{rd: 5'd26, data: 32'hD2});
        drive_alu(5'd1, 32'hC1);
        drive_mem(5'd24, 32'hD0);
        tick();
        drive_alu(5'd2, 32'hC2);
        drive_mem(5'd25, 32'hD1);
        tick();
        bus.alu_valid_i = 1'b0;
        drive_mem(5'd26, 32'hD2);
        #1;
        total++; if (bus.mem_ready_o !== 1'b0) begin bad++; $display("FAIL full_mem_ready got %b required 0", bus.mem_ready_o); end
        total++; if (bus.pending_o !== 32'h0300_0000) begin bad++; $display("FAIL full_pending got %h required 03000000", bus.pending_o); end
        tick();
        #1;
        total++; if (bus.mem_ready_o !== 1'b1) begin bad++; $display("FAIL full_mem_ready_after got %b required 1", bus.mem_ready_o); end
        total++; if (bus.pending_o !== 32'h0200_0000) begin bad++; $display("FAIL full_pending_pop got %h required 02000000", bus.pending_o); end
        tick();
        idle();
        #1;
        total++; if (bus.pending_o !== 32'h0400_0000) begin bad++; $display("FAIL full_pending_push got %h required 04000000", bus.pending_o); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        drive_alu(5'd4, 32'hE0);
        drive_mem(5'd27, 32'hF0);
        exp_q.push_back(wb_req_t'{rd: 5'd4, data: 32'hE0});
        tick();
        drive_alu(5'd5, 32'hE1);
        drive_mem(5'd28, 32'hF1);
        exp_q.push_back(wb_req_t'{rd: 5'd5, data: 32'hE1});
        tick();
        idle();
        rst = 1'b1;
        #1;
        total++; if (bus.pending_o !== 32'h1800_0000) begin bad++; $display("FAIL rm_pending_before got %h required 18000000", bus.pending_o); end
        total++; if (bus.mem_ready_o !== 1'b0) begin bad++; $display("FAIL rm_mem_ready got %b required 0", bus.mem_ready_o); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.wr_en_o !== 1'b0) begin bad++; $display("FAIL rm_wr_en got %b required 0", bus.wr_en_o); end
        total++; if (bus.pending_o !== 32'd0) begin bad++; $display("FAIL rm_pending got %h required 0", bus.pending_o); end
        total++; if (bus.alu_stall_o !== 1'b0) begin bad++; $display("FAIL rm_stall got %b required 0", bus.alu_stall_o); end
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_collision();
        test_backpressure();
        test_x0();
        test_full_pushpop();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drained_queue got %0d outstanding writes, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
